// File: rtl/sum_pair_serializer.sv
// Buffers {z1, z0} sum pairs in a small FIFO and emits them as a z0-then-z1 byte
// stream under valid/ready, counting pairs that break z1 == z0 + 1 (mod 256).
module sum_pair_serializer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       in_valid,
  input  logic [7:0] in_z0,
  input  logic [7:0] in_z1,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic [7:0] err_cnt,
  output logic       err_seen
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    SEL_Z0 = 1'b0,
    SEL_Z1 = 1'b1
  } sel_t;

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  sel_t        sel;
  sel_t        next_sel;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop_beat;
  logic        pop_pair;
  logic [15:0] head;
  logic [7:0]  z0_plus_one;
  logic        violation;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Flow control looks at registered state only, so a full FIFO refuses a push
  // even when the head pair drains on the same edge.
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push     = in_valid && in_ready;
  assign pop_beat = out_valid && out_ready;
  assign pop_pair = pop_beat && (sel == SEL_Z1);

  assign head     = mem[rd_ptr[AW-1:0]];
  assign out_data = out_valid ? ((sel == SEL_Z1) ? head[15:8] : head[7:0]) : 8'h00;
  assign out_last = (sel == SEL_Z1) && out_valid;

  assign z0_plus_one = in_z0 + 8'd1;
  assign violation   = (in_z1 != z0_plus_one);

  // NOTE: the storage array carries no reset; stale entries are never visible
  // because out_valid is gated by count, which is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_z1, in_z0};
    end
  end

  // NOTE: every output of this block gets a default before any branch so no
  // latch is inferred.
  always_comb begin
    next_sel = sel;
    if (pop_beat) begin
      next_sel = (sel == SEL_Z0) ? SEL_Z1 : SEL_Z0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sel <= SEL_Z0;
    end else begin
      sel <= next_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_pair) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_pair})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The pair is stored whatever the check says; only the error state reacts.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      err_cnt  <= 8'd0;
      err_seen <= 1'b0;
    end else if (push && violation) begin
      err_seen <= 1'b1;
      if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sum_pair_serializer.sv
// Directed bench for sum_pair_serializer: single pair, fill/backpressure,
// full-with-pop refusal, wrap legality, error saturation, stall and async reset.
module tb_sum_pair_serializer;

  logic       clk;
  logic       reset_;
  logic       in_valid;
  logic [7:0] in_z0;
  logic [7:0] in_z1;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic [7:0] err_cnt;
  logic       err_seen;

  int n_cmp = 0;
  int n_err = 0;

  sum_pair_serializer #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in_z0     (in_z0),
    .in_z1     (in_z1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err_cnt   (err_cnt),
    .err_seen  (err_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d, input logic last);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_last"}, out_last, last);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, 8'h00);
    check({tag, "_last"}, out_last, 1'b0);
  endtask

  logic [7:0] fill_z0 [5];
  int acc;
  int cyc;

  initial begin
    reset_    = 1'b0;
    in_valid  = 1'b0;
    in_z0     = 8'h00;
    in_z1     = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fill_z0[i] = 8'h20 + 8'(2 * i);

    // Reset state
    step();
    step();
    check("rst_in_ready", in_ready, 1'b1);
    expect_idle("rst");
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_err_seen", err_seen, 1'b0);
    reset_ = 1'b1;
    step();

    // Single consistent pair, out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_z0     = 8'h12;
    in_z1     = 8'h13;
    step();
    in_valid = 1'b0;
    expect_byte("single_z0", 8'h12, 1'b0);
    step();
    expect_byte("single_z1", 8'h13, 1'b1);
    step();
    expect_idle("single_after");
    check("single_err_cnt", err_cnt, 8'd0);

    // Fill four pairs with out_ready low; the fifth is held off
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_ready_%0d", i), in_ready, 1'b1);
      in_valid = 1'b1;
      in_z0    = fill_z0[i];
      in_z1    = fill_z0[i] + 8'd1;
      step();
    end
    in_z0 = fill_z0[4];
    in_z1 = fill_z0[4] + 8'd1;
    check("fill_full_ready", in_ready, 1'b0);
    step();
    check("fill_held_ready", in_ready, 1'b0);
    expect_byte("fill_stall", fill_z0[0], 1'b0);

    // Drain with pair 4 still offered: full + sel=1 pop must refuse it
    out_ready = 1'b1;
    step();
    check("full_pop_ready", in_ready, 1'b0);
    expect_byte("drain0_z1", fill_z0[0] + 8'd1, 1'b1);
    step();
    check("after_pop_ready", in_ready, 1'b1);
    expect_byte("drain1_z0", fill_z0[1], 1'b0);
    step();
    in_valid = 1'b0;
    expect_byte("drain1_z1", fill_z0[1] + 8'd1, 1'b1);
    step();
    for (int i = 2; i < 5; i++) begin
      expect_byte($sformatf("drain%0d_z0", i), fill_z0[i], 1'b0);
      step();
      expect_byte($sformatf("drain%0d_z1", i), fill_z0[i] + 8'd1, 1'b1);
      step();
    end
    expect_idle("drain_empty");
    check("fill_err_cnt", err_cnt, 8'd0);

    // Wrap pair FF/00 is legal
    in_valid = 1'b1;
    in_z0    = 8'hFF;
    in_z1    = 8'h00;
    step();
    in_valid = 1'b0;
    check("wrap_err_cnt", err_cnt, 8'd0);
    check("wrap_err_seen", err_seen, 1'b0);
    expect_byte("wrap_z0", 8'hFF, 1'b0);
    step();
    expect_byte("wrap_z1", 8'h00, 1'b1);
    step();

    // Inconsistent pair is flagged but still emitted
    in_valid = 1'b1;
    in_z0    = 8'h10;
    in_z1    = 8'h12;
    step();
    in_valid = 1'b0;
    check("bad_err_cnt", err_cnt, 8'd1);
    check("bad_err_seen", err_seen, 1'b1);
    expect_byte("bad_z0", 8'h10, 1'b0);
    step();
    expect_byte("bad_z1", 8'h12, 1'b1);
    step();
    expect_idle("bad_after");

    // 300 more bad pairs: counter saturates at 255
    in_valid = 1'b1;
    in_z0    = 8'h01;
    in_z1    = 8'h05;
    acc = 0;
    cyc = 0;
    while (acc < 300 && cyc < 3000) begin
      if (in_ready) begin
        acc++;
        step();
        if (acc == 253) check("sat_err_254", err_cnt, 8'd254);
        if (acc == 254) check("sat_err_255", err_cnt, 8'd255);
      end else begin
        step();
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("sat_accepted", acc, 300);
    check("sat_err_cnt", err_cnt, 8'd255);
    check("sat_err_seen", err_seen, 1'b1);
    cyc = 0;
    while (out_valid && cyc < 3000) begin
      step();
      cyc++;
    end
    expect_idle("sat_drained");

    // Mid-pair stall, then asynchronous reset with a second pair queued
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_z0     = 8'h40;
    in_z1     = 8'h41;
    step();
    in_valid = 1'b0;
    expect_byte("stall_z0", 8'h40, 1'b0);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_z0     = 8'h50;
    in_z1     = 8'h51;
    for (int i = 0; i < 3; i++) begin
      expect_byte($sformatf("stall_hold_%0d", i), 8'h41, 1'b1);
      step();
      in_valid = 1'b0;
    end
    #2;
    reset_ = 1'b0;
    #1;
    expect_idle("async_rst");
    check("async_rst_in_ready", in_ready, 1'b1);
    check("async_rst_err_cnt", err_cnt, 8'd0);
    check("async_rst_err_seen", err_seen, 1'b0);
    step();
    reset_ = 1'b1;
    out_ready = 1'b1;
    step();
    expect_idle("post_rst_idle");

    // First byte after reset comes from the next new push
    in_valid = 1'b1;
    in_z0    = 8'h60;
    in_z1    = 8'h61;
    step();
    in_valid = 1'b0;
    expect_byte("post_rst_z0", 8'h60, 1'b0);
    step();
    expect_byte("post_rst_z1", 8'h61, 1'b1);
    step();
    expect_idle("post_rst_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sum_pair_serializer.md
# sum_pair_serializer

Downstream consumer of the dual-sum stage. Each accepted transfer carries a registered sum pair (z0 = a+b, z1 = a+b+1). The block buffers pairs in a small FIFO and emits them as a byte stream: z0 first, then z1, under a valid/ready handshake. It also checks that every accepted pair satisfies z1 == z0 + 1 (mod 256) and counts violations.

## Interface
- DEPTH, 4, FIFO capacity in pairs; power of two, at least 2.
- clk  input  1  single clock; all state changes on its rising edge.
- reset_  input  1  asynchronous, active-low reset.
- in_valid  input  1  pair on in_z0/in_z1 is valid this cycle.
- in_z0  input  8  first sum of the pair.
- in_z1  input  8  second sum of the pair.
- in_ready  output  1  block can accept a pair this cycle.
- out_valid  output  1  out_data holds a valid byte.
- out_data  output  8  serialized byte.
- out_last  output  1  high when out_data is the z1 (second) byte of a pair.
- out_ready  input  1  downstream accepts the byte this cycle.
- err_cnt  output  8  count of pair-consistency violations; saturates at 255.
- err_seen  output  1  sticky flag, set on the first violation.

## Operation
- **Storage**
  - DEPTH-entry array of 16-bit {z1, z0} entries.
  - Write and read pointers are log2(DEPTH)+1 bits wide; wrap is natural modulo 2·DEPTH.
  - full = (count == DEPTH), empty = (count == 0).
- **Push**
  - in_ready = !full, decoded from registered state only. It does not depend on out_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
  - When in_valid && in_ready, {in_z1, in_z0} is written at the write pointer and the write pointer increments.
- **Phase bit sel** (two states: SEL_Z0 = 0, SEL_Z1 = 1)
  - out_valid = !empty.
  - out_data = sel ? head.z1 : head.z0 when out_valid is high; otherwise 8'h00.
  - out_last = sel && out_valid.
- **Pop**
  - On out_valid && out_ready with sel = 0: sel becomes 1.
  - On out_valid && out_ready with sel = 1: sel becomes 0, the read pointer increments and count decrements.
  - With out_ready low, out_data and out_last are held stable.
- **Simultaneous push and pop** (the pop being a sel = 1 beat): count is unchanged and both pointers advance.
- **Consistency check**, evaluated on every accepted push:
  - Violation when in_z1 != (in_z0 + 8'd1) mod 256. So z0 = FF with z1 = 00 is legal.
  - On a violation, err_cnt increments (holding at 255) and err_seen is set.
  - The pair is stored and emitted regardless of the check result.
- **Reset**, asserted asynchronously:
  - Clears pointers, count, sel, err_cnt and err_seen.
  - Output values during reset: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, err_cnt = 0, err_seen = 0.
  - Array contents are not reset.
  - Reset mid-pair (sel = 1) discards the partial pair, and all queued pairs are lost.

## Timing
- A pair pushed at edge N gives out_valid = 1 in cycle N+1, with z0 on out_data. There is no combinational in-to-out path.
- Maximum throughput is one byte per cycle, i.e. one pair per two cycles. The upstream stage produces one pair per cycle, so in_ready deasserts under sustained input.
- in_ready, out_valid, out_data and out_last depend only on registered state.
- err_cnt and err_seen update at the edge that accepts the violating pair.

## Test plan
- **Single pair, consistent:** push {z0 = 0x12, z1 = 0x13}, out_ready held 1 -> bytes 0x12 (last = 0) in cycle N+1 and 0x13 (last = 1) in cycle N+2; out_valid = 0 afterwards; err_cnt = 0.
- **Fill and backpressure** (DEPTH = 4): push 5 pairs back-to-back with out_ready = 0 -> in_ready drops after the 4th pair and the 5th is held. Then out_ready = 1 -> 8 bytes emitted in order with out_last alternating 0,1. The 5th pair is accepted at the cycle after the first pop.
- **Full with simultaneous pop:** FIFO full, sel = 1, out_ready = 1, in_valid = 1 -> pair not accepted that cycle; accepted next cycle (in_ready = 1); no entry lost or duplicated.
- **Wrap and consistency:** push {0xFF, 0x00} -> no error. Push {0x10, 0x12} -> err_cnt = 1, err_seen = 1, and bytes 0x10, 0x12 still emitted. 300 bad pairs -> err_cnt saturates at 255.
- **Mid-pair stall and reset:** emit z0 of a pair, hold out_ready = 0 for 3 cycles -> out_data is stable at z1 with out_last = 1. Assert reset_ = 0 asynchronously -> out_valid = 0, in_ready = 1, err_cnt = 0 immediately. After release, the first byte emitted comes from the next new push.
